// File: rtl/multiplier_control_pkg.sv
// Shared types for the shift-add multiplier sequencer: state encoding, the
// registered control-output bundle and the per-state output decode.
package multiplier_control_pkg;

  localparam int N_DEFAULT     = 32;
  localparam int CNT_W_DEFAULT = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LSB   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic init;
    logic l_lsb;
    logic shift_load;
    logic cycle_finish;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore output pattern for a state; lsb_select is handled separately because it depends on lsb_q
  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c = '{init: 1'b0, l_lsb: 1'b0, shift_load: 1'b1, cycle_finish: 1'b0, busy: 1'b1, done: 1'b0};
    case (s)
      ST_IDLE:  c.busy         = 1'b0;
      ST_INIT:  c.init         = 1'b1;
      ST_LSB:   c.l_lsb        = 1'b1;
      ST_SHIFT: c.shift_load   = 1'b0;
      ST_STORE: c.cycle_finish = 1'b1;
      ST_DONE:  c.done         = 1'b1;
      default:  c.busy         = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multiplier_control_iter_counter.sv
// Iteration counter for the multiplier sequencer: cleared in INIT, bumped once
// per STORE, flags the final iteration. Saturates at N.
module mult_iter_counter
  import multiplier_control_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, increment holds once N is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != CNT_W'(N))) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/multiplier_control.sv
// Moore sequencer for the 32-bit shift-add multiplier datapath.
// Optional iteration cross-check against the datapath's i_eq_0 flag: MULT_ITER_CHECK_EN.
module multiplier_control
  import multiplier_control_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic p_lsb,
  input  logic i_eq_0,
  output logic init,
  output logic l_lsb,
  output logic shift_load,
  output logic lsb_select,
  output logic cycle_finish,
  output logic busy,
  output logic done,
  output logic err
);

  state_e state_q;
  state_e state_d;
  logic   lsb_q;
  logic   lsb_d;
  logic   err_q;
  logic   err_d;
  ctrl_t  ctrl_q;
  logic   lsb_select_q;
  logic   last_s;

  mult_iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == ST_INIT),
    .inc   (state_q == ST_STORE),
    .last  (last_s)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT:  state_d = ST_LSB;
      ST_LSB:   state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_STORE;
      ST_STORE: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LSB;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Multiplier LSB capture and sticky iteration-mismatch flag
  always_comb begin
    lsb_d = lsb_q;
    err_d = err_q;
    if (state_q == ST_LSB) begin
      lsb_d = p_lsb;
    end else begin
      lsb_d = lsb_q;
    end
`ifdef MULT_ITER_CHECK_EN
    if (state_q == ST_INIT) begin
      err_d = 1'b0;
    end else if ((state_q == ST_STORE) && (last_s != i_eq_0)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
`else
    // i_eq_0 stays on the port for interface stability but has no effect here
    err_d = 1'b0 & i_eq_0;
`endif
  end

  // State, LSB and error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lsb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lsb_q   <= lsb_d;
      err_q   <= err_d;
    end
  end

  // Outputs are flopped from the next-state decode, so they line up with state_q exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q       <= decode_state(ST_IDLE);
      lsb_select_q <= 1'b0;
    end else begin
      ctrl_q       <= decode_state(state_d);
      lsb_select_q <= (state_d == ST_STORE) ? lsb_d : 1'b0;
    end
  end

  assign init         = ctrl_q.init;
  assign l_lsb        = ctrl_q.l_lsb;
  assign shift_load   = ctrl_q.shift_load;
  assign cycle_finish = ctrl_q.cycle_finish;
  assign busy         = ctrl_q.busy;
  assign done         = ctrl_q.done;
  assign lsb_select   = lsb_select_q;
  assign err          = err_q;

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: a behavioural shift-add datapath closes the loop
// around a 32-iteration instance; a second N=4 instance checks the short build.
module tb_multiplier_control;

  localparam int N = 32;
`ifdef MULT_ITER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic p_lsb, i_eq_0;
  logic init, l_lsb, shift_load, lsb_select, cycle_finish, busy, done, err;

  logic start4 = 1'b0;
  logic i_eq_0_4;
  logic init4, l_lsb4, shift_load4, lsb_select4, cycle_finish4, busy4, done4, err4;

  int tests = 0;
  int fails = 0;
  logic err_exp = 1'b0;
  logic force_ieq = 1'b0;

  // datapath model
  logic [31:0] mp_v = 32'd0;
  logic [31:0] mc_v = 32'd0;
  logic [31:0] a_m, q_m, m_m;
  logic [5:0]  i_m;
  logic [32:0] dp_sum;
  logic [64:0] dp_shift;
  logic [2:0]  cf_cnt4;

  always #5 clk = ~clk;

  multiplier_control #(.N(N), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .p_lsb(p_lsb), .i_eq_0(i_eq_0),
    .init(init), .l_lsb(l_lsb), .shift_load(shift_load), .lsb_select(lsb_select),
    .cycle_finish(cycle_finish), .busy(busy), .done(done), .err(err)
  );

  multiplier_control #(.N(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .p_lsb(1'b1), .i_eq_0(i_eq_0_4),
    .init(init4), .l_lsb(l_lsb4), .shift_load(shift_load4), .lsb_select(lsb_select4),
    .cycle_finish(cycle_finish4), .busy(busy4), .done(done4), .err(err4)
  );

  assign p_lsb    = q_m[0];
  assign i_eq_0   = (i_m == 6'd0) | force_ieq;
  assign dp_sum   = {1'b0, a_m} + {1'b0, (lsb_select ? m_m : 32'd0)};
  assign dp_shift = {dp_sum, q_m} >> 1;
  assign i_eq_0_4 = (cf_cnt4 == 3'd3);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_m <= 32'd0; q_m <= 32'd0; m_m <= 32'd0; i_m <= 6'd0;
    end else if (init) begin
      a_m <= 32'd0; q_m <= mp_v; m_m <= mc_v; i_m <= 6'(N - 1);
    end else if (cycle_finish) begin
      a_m <= dp_shift[63:32];
      q_m <= dp_shift[31:0];
      i_m <= (i_m == 6'd0) ? 6'd0 : i_m - 6'd1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cf_cnt4 <= 3'd0;
    else if (init4) cf_cnt4 <= 3'd0;
    else if (cycle_finish4) cf_cnt4 <= cf_cnt4 + 3'd1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; start4 = 1'b0; force_ieq = 1'b0; err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_state();
    logic [6:0] got;
    got = {busy, init, l_lsb, shift_load, lsb_select, cycle_finish, done};
    tests++;
    if (got !== 7'b0001000 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got outputs %b err %b, expected 0001000 err 0", got, err);
    end
  endtask

  // mode 0: single pulse; 1: start held high; 2: extra start pulses while busy
  task automatic run_mult(input string name, input logic [31:0] mp, input logic [31:0] mc,
                          input logic [63:0] exp_prod, input int mode, input int force_cyc);
    logic [6:0] exp_o, got_o;
    int k;
    int ph;
    @(negedge clk);
    mp_v = mp; mc_v = mc; start = 1'b1;
    for (int c = 1; c <= 3*N + 4; c++) begin
      @(negedge clk);
      force_ieq = (c == force_cyc);
      if (mode == 1) start = 1'b1;
      else if (mode == 2 && (c == 10 || c == 50 || c == 3*N + 2)) start = 1'b1;
      else start = 1'b0;
      exp_o = 7'b0001000;
      if (c == 1) begin
        exp_o = 7'b1101000;
      end else if (c <= 1 + 3*N) begin
        k = (c - 2) / 3;
        ph = (c - 2) % 3;
        if (ph == 0) exp_o = 7'b1011000;
        else if (ph == 1) exp_o = 7'b1000000;
        else exp_o = {4'b1001, mp[k], 2'b10};
      end else if (c == 2 + 3*N) begin
        exp_o = 7'b1001001;
      end else if (c == 3*N + 4 && mode == 1) begin
        exp_o = 7'b1101000;
      end
      if (c == 2) err_exp = 1'b0;
      if (force_cyc > 0 && c == force_cyc + 1) err_exp = CHK;
      got_o = {busy, init, l_lsb, shift_load, lsb_select, cycle_finish, done};
      tests++;
      if (got_o !== exp_o) begin
        fails++;
        $display("FAIL %s cycle %0d: got {busy,init,l_lsb,shift_load,lsb_select,cycle_finish,done}=%b expected %b",
                 name, c, got_o, exp_o);
      end
      tests++;
      if (err !== err_exp) begin
        fails++;
        $display("FAIL %s_err cycle %0d: got %b expected %b", name, c, err, err_exp);
      end
    end
    start = 1'b0; force_ieq = 1'b0;
    tests++;
    if ({a_m, q_m} !== exp_prod) begin
      fails++;
      $display("FAIL %s_product: got %h expected %h", name, {a_m, q_m}, exp_prod);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [6:0] got;
    logic seen;
    @(negedge clk);
    mp_v = 32'd7; mc_v = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (shift_load !== 1'b0) begin
      fails++;
      $display("FAIL reset_reach_shift: shift_load got %b expected 0", shift_load);
    end
    #2 rst = 1'b1;
    #1;
    got = {busy, init, l_lsb, shift_load, lsb_select, cycle_finish, done};
    tests++;
    if (got !== 7'b0001000 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_shift: got %b err %b expected 0001000 err 0", got, err);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3*N + 10; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: busy/done seen after reset got 1 expected 0");
    end
  endtask

  task automatic test_n4();
    int cf;
    int done_at;
    cf = 0; done_at = -1;
    @(negedge clk); start4 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (cycle_finish4 === 1'b1) cf++;
      if (done4 === 1'b1 && done_at < 0) done_at = c;
      tests++;
      if (err4 !== 1'b0) begin
        fails++;
        $display("FAIL n4_err cycle %0d: got %b expected 0", c, err4);
      end
    end
    tests++;
    if (done_at != 14) begin
      fails++;
      $display("FAIL n4_done_cycle: got %0d expected 14", done_at);
    end
    tests++;
    if (cf != 4) begin
      fails++;
      $display("FAIL n4_cycle_finish_count: got %0d expected 4", cf);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset_state();
    rst = 1'b0;
    run_mult("mult_2x3", 32'd2, 32'd3, 64'd6, 0, 0);
    do_reset();
    run_mult("mult_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0);
    do_reset();
    run_mult("start_held", 32'd5, 32'd11, 64'd55, 1, 0);
    do_reset();
    run_mult("busy_pulses", 32'h8000_0001, 32'd5, 64'h0000_0002_8000_0005, 2, 0);
    do_reset();
    run_mult("err_force", 32'd3, 32'd4, 64'd12, 0, 19);
    run_mult("err_clear", 32'd6, 32'd7, 64'd42, 0, 0);
    do_reset();
    test_reset_mid_shift();
    do_reset();
    test_n4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
